// File: rtl/systolic_n_body_step_controller.sv
// systolic_n_body_step_controller
//
// Control sequencer for the 2x2 systolic n-body datapath. For each timestep
// it clears the acceleration accumulators, feeds every (i-block, j-block)
// tile pair into the cell array in row-major order, waits out the array
// latency, captures the accelerations, then walks the Verlet integrator
// over every body. It repeats for the requested number of timesteps.
//
// Ports:
//   clk          single rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a run (sampled only in IDLE)
//   num_steps    timestep count, latched when start is accepted
//   abort        synchronous cancel of the current run
//   busy         high in every state except IDLE
//   done         one-cycle pulse on normal completion
//   acc_clear    clear accelerator partial sums
//   feed_valid   tile pair presented to the array this cycle
//   feed_i_blk   row block of the tile being fed (0 when not feeding)
//   feed_j_blk   column block of the tile being fed (0 when not feeding)
//   capture_acc  latch accelerations from the array
//   integ_en     integrator updates body integ_idx this cycle
//   integ_idx    body index for integration (0 when not integrating)
//   step_count   timesteps completed in the current or last run
module systolic_n_body_step_controller #(
  parameter  int unsigned NUM_BODIES = 4,
  parameter  int unsigned ARRAY_DIM  = 2,
  parameter  int unsigned PIPE_LAT   = 3,
  parameter  int unsigned STEP_W     = 16,
  localparam int unsigned BLKS       = NUM_BODIES / ARRAY_DIM,
  localparam int unsigned TILES      = BLKS * BLKS,
  localparam int unsigned BW         = (BLKS > 1) ? $clog2(BLKS) : 1,
  localparam int unsigned IW         = (NUM_BODIES > 1) ? $clog2(NUM_BODIES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              acc_clear,
  output logic              feed_valid,
  output logic [BW-1:0]     feed_i_blk,
  output logic [BW-1:0]     feed_j_blk,
  output logic              capture_acc,
  output logic              integ_en,
  output logic [IW-1:0]     integ_idx,
  output logic [STEP_W-1:0] step_count
);

  // One phase counter is shared by FEED, DRAIN and INTEG; size it for the
  // longest of the three.
  localparam int unsigned MAXC0 = (TILES > PIPE_LAT) ? TILES : PIPE_LAT;
  localparam int unsigned MAXC  = (MAXC0 > NUM_BODIES) ? MAXC0 : NUM_BODIES;
  localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] FEED_LAST  = CW'(TILES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_LAT - 1);
  localparam logic [CW-1:0] INTEG_LAST = CW'(NUM_BODIES - 1);
  localparam logic [BW-1:0] J_LAST     = BW'(BLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_INTEG,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_i_blk;
  logic [BW-1:0]     r_j_blk;
  logic [STEP_W-1:0] r_num;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_inc;
  logic              w_integ_last;

  assign w_step_inc   = r_step + STEP_W'(1);
  assign w_integ_last = (r_state == S_INTEG) && (r_cnt == INTEG_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_nxt = (num_steps == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:   w_state_nxt = S_FEED;
      S_FEED:    if (r_cnt == FEED_LAST) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (r_cnt == DRAIN_LAST) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_INTEG;
      // Equality test against the incremented count, so an all-ones
      // num_steps finishes before r_step could ever wrap.
      S_INTEG:   if (r_cnt == INTEG_LAST)
                   w_state_nxt = (w_step_inc == r_num) ? S_DONE : S_CLEAR;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_i_blk <= '0;
      r_j_blk <= '0;
      r_num   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Phase counters restart on every state change so each counted state
      // begins at index 0.
      if (w_state_nxt != r_state) begin
        r_cnt   <= '0;
        r_i_blk <= '0;
        r_j_blk <= '0;
      end else if ((r_state == S_FEED) || (r_state == S_DRAIN) ||
                   (r_state == S_INTEG)) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_state == S_FEED) begin
          if (r_j_blk == J_LAST) begin
            r_j_blk <= '0;
            r_i_blk <= r_i_blk + BW'(1);
          end else begin
            r_j_blk <= r_j_blk + BW'(1);
          end
        end
      end

      if ((r_state == S_IDLE) && start) begin
        r_num  <= num_steps;
        r_step <= '0;
      end else if (w_integ_last) begin
        r_step <= w_step_inc;
      end
    end
  end

  // Strobes decode straight from the state register, so an abort or reset
  // edge drops them all in the very next cycle and they can never overlap.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign acc_clear   = (r_state == S_CLEAR);
  assign feed_valid  = (r_state == S_FEED);
  assign capture_acc = (r_state == S_CAPTURE);
  assign integ_en    = (r_state == S_INTEG);
  assign feed_i_blk  = feed_valid ? r_i_blk : '0;
  assign feed_j_blk  = feed_valid ? r_j_blk : '0;
  assign integ_idx   = integ_en ? r_cnt[IW-1:0] : '0;
  assign step_count  = r_step;

endmodule

// File: tb/tb_systolic_n_body_step_controller.sv
module tb_systolic_n_body_step_controller;

  localparam logic [4:0] CLR = 5'b00001;
  localparam logic [4:0] FED = 5'b00010;
  localparam logic [4:0] CAP = 5'b00100;
  localparam logic [4:0] INT = 5'b01000;
  localparam logic [4:0] DN  = 5'b10000;

  logic        clk;
  logic        rst;
  logic        start, abort;
  logic [15:0] num_steps;
  logic        busy, done, acc_clear, feed_valid, capture_acc, integ_en;
  logic [0:0]  feed_i_blk, feed_j_blk;
  logic [1:0]  integ_idx;
  logic [15:0] step_count;

  logic        start8, abort8;
  logic [15:0] num8;
  logic        b8, d8, ac8, fv8, ca8, ie8;
  logic [1:0]  fi8, fj8;
  logic [2:0]  ii8;
  logic [15:0] sc8;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  int m_clr, m_feed, m_int, m_done, m_done_at, m_ended;
  int m_cap[$];

  systolic_n_body_step_controller #(
    .NUM_BODIES(4), .ARRAY_DIM(2), .PIPE_LAT(3), .STEP_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps), .abort(abort),
    .busy(busy), .done(done), .acc_clear(acc_clear), .feed_valid(feed_valid),
    .feed_i_blk(feed_i_blk), .feed_j_blk(feed_j_blk), .capture_acc(capture_acc),
    .integ_en(integ_en), .integ_idx(integ_idx), .step_count(step_count)
  );

  systolic_n_body_step_controller #(
    .NUM_BODIES(8), .ARRAY_DIM(2), .PIPE_LAT(1), .STEP_W(16)
  ) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .num_steps(num8), .abort(abort8),
    .busy(b8), .done(d8), .acc_clear(ac8), .feed_valid(fv8),
    .feed_i_blk(fi8), .feed_j_blk(fj8), .capture_acc(ca8),
    .integ_en(ie8), .integ_idx(ii8), .step_count(sc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [4:0] strb4();
    return {done, integ_en, capture_acc, feed_valid, acc_clear};
  endfunction

  function automatic logic [4:0] strb8();
    return {d8, ie8, ca8, fv8, ac8};
  endfunction

  // Observes the 4-body DUT from the current cycle (numbered 1) until busy
  // drops, counting strobes.
  task automatic meas4(input int maxc);
    m_clr = 0; m_feed = 0; m_int = 0; m_done = 0; m_done_at = 0; m_ended = 0;
    m_cap.delete();
    for (int c = 1; c <= maxc; c++) begin
      if (!busy) begin
        m_ended = 1;
        break;
      end
      if (acc_clear)   m_clr++;
      if (feed_valid)  m_feed++;
      if (capture_acc) m_cap.push_back(c);
      if (integ_en)    m_int++;
      if (done) begin
        m_done++;
        m_done_at = c;
      end
      tick();
    end
    chk("run_ends", m_ended, 1);
  endtask

  // Strobe exclusivity and idle-index zeroing, every cycle, both instances.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("excl4", ($countones(strb4()) <= 1), 1);
      chk("excl8", ($countones(strb8()) <= 1), 1);
      chk("idx0_4", ((!feed_valid && (feed_i_blk != 0 || feed_j_blk != 0)) ||
                     (!integ_en && integ_idx != 0)), 0);
      chk("idx0_8", ((!fv8 && (fi8 != 0 || fj8 != 0)) || (!ie8 && ii8 != 0)), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m, ended, dn, dn_at;
    int caps8[$];
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0;
    start8 = 1'b0; abort8 = 1'b0; num8 = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_strb", strb4(), 0);
    chk("rst_steps", step_count, 0);
    chk("rst_idx", {feed_i_blk, feed_j_blk, integ_idx}, 0);
    chk("rst_busy8", b8, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single step, cycle by cycle.
    num_steps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0; num_steps = 16'hFFFF;  // must be ignored while busy
    chk("t1_clear", strb4(), CLR);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_feed", strb4(), FED);
      chk("t1_fi", feed_i_blk, i / 2);
      chk("t1_fj", feed_j_blk, i % 2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_drain", strb4(), 0);
      chk("t1_drain_busy", busy, 1);
    end
    tick();
    chk("t1_cap", strb4(), CAP);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_integ", strb4(), INT);
      chk("t1_idx", integ_idx, i);
    end
    tick();
    chk("t1_done", strb4(), DN);
    chk("t1_done_steps", step_count, 1);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_strb", strb4(), 0);
    chk("t1_hold_steps", step_count, 1);

    // Three steps.
    num_steps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    meas4(200);
    chk("t3_clears", m_clr, 3);
    chk("t3_feeds", m_feed, 12);
    chk("t3_caps", m_cap.size(), 3);
    if (m_cap.size() == 3) begin
      chk("t3_cap0", m_cap[0], 9);
      chk("t3_gap1", m_cap[1] - m_cap[0], 13);
      chk("t3_gap2", m_cap[2] - m_cap[1], 13);
    end
    chk("t3_integs", m_int, 12);
    chk("t3_dones", m_done, 1);
    chk("t3_done_at", m_done_at, 40);
    chk("t3_steps", step_count, 3);

    // Zero steps.
    num_steps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t0_done", strb4(), DN);
    chk("t0_busy", busy, 1);
    chk("t0_steps", step_count, 0);
    tick();
    chk("t0_idle", busy, 0);
    chk("t0_idle_strb", strb4(), 0);

    // start held across DONE -> IDLE: one idle cycle between runs.
    start = 1'b1;
    tick();
    chk("b2b_done1", strb4(), DN);
    tick();
    chk("b2b_idle", busy, 0);
    tick();
    chk("b2b_done2", strb4(), DN);
    start = 1'b0;
    tick();
    chk("b2b_end", busy, 0);

    // abort and start on the same IDLE edge: start wins.
    num_steps = 16'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("as_clear", strb4(), CLR);
    meas4(60);
    chk("as_done_at", m_done_at, 14);
    chk("as_steps", step_count, 1);

    // Abort during the second step's FEED.
    num_steps = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("ab_feed", strb4(), FED);
    chk("ab_fj", feed_j_blk, 1);
    chk("ab_steps_pre", step_count, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_strb", strb4(), 0);
    chk("ab_steps", step_count, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ab_quiet", {busy, strb4()}, 0);
    end
    num_steps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    meas4(60);
    chk("ab_rerun_done_at", m_done_at, 14);
    chk("ab_rerun_dones", m_done, 1);
    chk("ab_rerun_steps", step_count, 1);

    // Reset during step-2 INTEG with start on the same edge.
    num_steps = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (23) tick();
    chk("rs_integ", strb4(), INT);
    chk("rs_idx", integ_idx, 1);
    chk("rs_steps_pre", step_count, 1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_strb", strb4(), 0);
    chk("rs_steps", step_count, 0);
    chk("rs_idx0", integ_idx, 0);
    tick();
    chk("rs_no_run", busy, 0);

    // start pulse while busy is ignored.
    num_steps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; num_steps = 16'd3;
    tick();
    start = 1'b0;
    meas4(60);
    chk("ig_dones", m_done, 1);
    chk("ig_caps", m_cap.size(), 1);
    chk("ig_integs", m_int, 4);
    chk("ig_steps", step_count, 1);

    // Parameter sweep: 8 bodies, PIPE_LAT=1, two steps.
    num8 = 16'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    k = 0; m = 0; ended = 0; dn = 0; dn_at = 0;
    for (int c = 1; c <= 120; c++) begin
      if (!b8) begin
        ended = 1;
        break;
      end
      if (fv8) begin
        chk("p8_fi", fi8, (k % 16) / 4);
        chk("p8_fj", fj8, k % 4);
        k++;
      end
      if (ie8) begin
        chk("p8_idx", ii8, m % 8);
        m++;
      end
      if (ca8) caps8.push_back(c);
      if (d8) begin
        dn++;
        dn_at = c;
      end
      tick();
    end
    chk("p8_ends", ended, 1);
    chk("p8_feeds", k, 32);
    chk("p8_integs", m, 16);
    chk("p8_caps", caps8.size(), 2);
    if (caps8.size() == 2) begin
      chk("p8_cap0", caps8[0], 19);
      chk("p8_gap", caps8[1] - caps8[0], 27);
    end
    chk("p8_dones", dn, 1);
    chk("p8_done_at", dn_at, 55);
    chk("p8_steps", sc8, 2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
